// File: rtl/fsm_send_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fsm_send_pkg                                            |
// | Purpose  : Shared state encodings, byte constants and byte-select  |
// |            helper for the debugger transmit sequencer.             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package fsm_send_pkg;

  // A source word is always serialised as four bytes.
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Sequencer states; the CHK_* pair is only reachable with the checksum trailer built in.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_TX  = 3'd4,
    ST_DONE     = 3'd5,
    ST_CHK_SEND = 3'd6,
    ST_CHK_WAIT = 3'd7
  } state_t;

  // Little-endian byte select: index 0 returns bits [7:0].
  function automatic logic [7:0] pick_byte(
    input logic [BYTES_PER_WORD*8-1:0] word,
    input logic [BYTE_IDX_W-1:0]       idx
  );
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_send_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fsm_send_if                                             |
// | Purpose  : Source-read and UART byte handshake bundle of the       |
// |            transmit sequencer.                                     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface fsm_send_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              is_start;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] i_data;
  logic [7:0]        o_tx_data;
  logic              os_tx_start;
  logic              is_tx_done;
  logic              os_busy;
  logic              os_done;

  // Sequencer side.
  modport master (
    input  is_start, i_data, is_tx_done,
    output o_address, o_tx_data, os_tx_start, os_busy, os_done
  );

  // Source memory, UART transmitter and controlling logic side.
  modport slave (
    output is_start, i_data, is_tx_done,
    input  o_address, o_tx_data, os_tx_start, os_busy, os_done
  );

endinterface
`default_nettype wire

// File: rtl/fsm_send_word_byte_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fsm_send_word_byte_serializer                           |
// | Purpose  : Holds one source word and presents a registered byte    |
// |            chosen by the sequencer's byte index.                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module fsm_send_word_byte_serializer
  import fsm_send_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     word_in,
  input  logic                  update,
  input  logic [BYTE_IDX_W-1:0] sel,
  input  logic                  inject,
  input  logic [7:0]            inject_byte,
  output logic [7:0]            byte_out
);

  logic [DATA_W-1:0] shift_reg;
  logic [7:0]        byte_sel;

  // On a load the incoming word is used directly so byte 0 appears with no extra cycle.
  always_comb begin
    byte_sel = pick_byte(load ? word_in : shift_reg, sel);
    if (inject) begin
      byte_sel = inject_byte;
    end
  end

  // Word capture and registered byte output; the byte holds until the next update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      byte_out  <= '0;
    end else begin
      if (load) begin
        shift_reg <= word_in;
      end
      if (update) begin
        byte_out <= byte_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsm_send.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fsm_send                                                |
// | Purpose  : Debugger transmit sequencer. Dumps N_WORDS source words |
// |            from address 0 as little-endian bytes over a UART       |
// |            start/done handshake and pulses os_done at the end.     |
// |            Define FSM_SEND_CHECKSUM_EN to append an XOR checksum    |
// |            byte after the data bytes.                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module fsm_send
  import fsm_send_pkg::*;
#(
  parameter int N_WORDS = 32,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  fsm_send_if.master bus
);

  // Index of the final word; word_cnt stops here so it can never wrap.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     word_cnt;
  logic [ADDR_W-1:0]     word_cnt_nxt;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic [BYTE_IDX_W-1:0] byte_cnt_nxt;
  logic                  load;
  logic                  update;
  logic                  inject;
  logic [ADDR_W-1:0]     address;
  logic                  tx_start;
  logic                  busy;
  logic                  done;
  logic [7:0]            tx_byte;
  logic [7:0]            chk_byte;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter updates and serializer controls.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    byte_cnt_nxt = byte_cnt;
    load         = 1'b0;
    update       = 1'b0;
    inject       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.is_start) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load         = 1'b1;
        update       = 1'b1;
        byte_cnt_nxt = '0;
        state_nxt    = ST_SEND;
      end
      ST_SEND: begin
        // A done strobe here is ignored: the transmitter cannot finish in zero cycles.
        state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.is_tx_done) begin
          if (byte_cnt != LAST_BYTE) begin
            byte_cnt_nxt = byte_cnt + 1'b1;
            update       = 1'b1;
            state_nxt    = ST_SEND;
          end else if (word_cnt != LAST_WORD) begin
            word_cnt_nxt = word_cnt + 1'b1;
            state_nxt    = ST_READ;
          end else begin
`ifdef FSM_SEND_CHECKSUM_EN
            inject    = 1'b1;
            update    = 1'b1;
            state_nxt = ST_CHK_SEND;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef FSM_SEND_CHECKSUM_EN
      ST_CHK_SEND: begin
        state_nxt = ST_CHK_WAIT;
      end
      ST_CHK_WAIT: begin
        if (bus.is_tx_done) begin
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        // is_start is not looked at here; a new dump needs a pass through IDLE.
        word_cnt_nxt = '0;
        state_nxt    = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      address  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      word_cnt <= word_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (state_nxt == ST_READ) begin
        address <= word_cnt_nxt;
      end
      tx_start <= (state_nxt == ST_SEND) || (state_nxt == ST_CHK_SEND);
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
    end
  end

`ifdef FSM_SEND_CHECKSUM_EN
  logic [7:0] checksum;

  // Running XOR of every byte put on the transmitter, restarted with each dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_READ)) begin
      checksum <= '0;
    end else if (state == ST_SEND) begin
      checksum <= checksum ^ tx_byte;
    end
  end

  assign chk_byte = checksum;
`else
  assign chk_byte = '0;
`endif

  fsm_send_word_byte_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .word_in     (bus.i_data),
    .update      (update),
    .sel         (byte_cnt_nxt),
    .inject      (inject),
    .inject_byte (chk_byte),
    .byte_out    (tx_byte)
  );

  assign bus.o_address   = address;
  assign bus.o_tx_data   = tx_byte;
  assign bus.os_tx_start = tx_start;
  assign bus.os_busy     = busy;
  assign bus.os_done     = done;

endmodule
`default_nettype wire
